// File: rtl/mem_access_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_access_unit_if
// Purpose  : Core-side request/response and BRAM-side bus of the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWrite;
    logic [3:0]  byteMask;
    logic [31:0] memReadData;

    // master = core plus BRAM side, slave = the access unit itself
    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, memReadData,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               memAddress, memWriteData, memWrite, byteMask
    );
    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, memReadData,
        output req_ready, resp_valid, resp_rdata, resp_error,
               memAddress, memWriteData, memWrite, byteMask
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_access_unit
// Purpose  : RISC-V load/store front end driving a word-wide BRAM port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int READ_LATENCY = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_access_unit_if.slave  bus
);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam int              c_CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(READ_LATENCY - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               r_write;
    logic [2:0]         r_funct3;
    logic [1:0]         r_lane;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_mask;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_illegal;
    logic               w_last_wait;
    logic [3:0]         w_mask;
    logic [31:0]        w_lane_data;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;

    assign w_accept    = bus.req_valid && bus.req_ready;
    assign w_last_wait = (r_state == c_WAIT) && (r_cnt == c_CNT_LAST);

    // funct3[1:0] is the access size; 2'b11 is never legal
    always_comb begin
        w_illegal = 1'b0;
        if (bus.req_write) begin
            if (bus.req_funct3[2] || bus.req_funct3 == 3'b011)
                w_illegal = 1'b1;
        end else begin
            if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 || bus.req_funct3 == 3'b111)
                w_illegal = 1'b1;
        end
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
            w_illegal = 1'b1;
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
            w_illegal = 1'b1;
    end

    always_comb begin
        w_mask      = 4'b1111;
        w_lane_data = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                w_mask      = 4'b0001 << bus.req_addr[1:0];
                w_lane_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_mask      = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = bus.memReadData[{r_lane, 3'b000} +: 8];
    assign w_half = bus.memReadData[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load = bus.memReadData;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: ;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_next = w_illegal ? c_RESP : c_ACCESS;
            c_ACCESS: w_next = r_write ? c_RESP : c_WAIT;
            c_WAIT:   if (w_last_wait) w_next = c_RESP;
            default:  w_next = c_IDLE;
        endcase
    end

    // FSM: outputs; strobes are gated by reset so an interrupted store never lands
    always_comb begin
        bus.req_ready    = (r_state == c_IDLE) && !reset;
        bus.resp_valid   = (r_state == c_RESP) && !reset;
        bus.memWrite     = (r_state == c_ACCESS) && r_write && !reset;
        bus.byteMask     = ((r_state == c_ACCESS) && r_write && !reset) ? r_mask : 4'b0000;
        bus.memAddress   = r_addr;
        bus.memWriteData = r_wdata;
        bus.resp_rdata   = r_rdata;
        bus.resp_error   = r_err;
    end

    // Response registers change only on entry to RESP so they hold between responses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_lane   <= 2'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_mask   <= 4'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_write  <= bus.req_write;
                r_funct3 <= bus.req_funct3;
                r_lane   <= bus.req_addr[1:0];
                r_addr   <= {bus.req_addr[31:2], 2'b00};
                r_wdata  <= w_lane_data;
                r_mask   <= w_mask;
                if (w_illegal) begin
                    r_rdata <= 32'd0;
                    r_err   <= 1'b1;
                end
            end
            if (r_state == c_ACCESS && r_write) begin
                r_rdata <= 32'd0;
                r_err   <= 1'b0;
            end
            if (w_last_wait) begin
                r_rdata <= w_load;
                r_err   <= 1'b0;
            end
            if (r_state == c_WAIT) r_cnt <= r_cnt + c_CNT_W'(1);
            else                   r_cnt <= '0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed scoreboard bench for mem_access_unit with a 1-cycle BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rd;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:63];

    mem_access_unit_if bus();

    mem_access_unit #(.READ_LATENCY(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read BRAM with byte-lane writes
    always @(posedge clk) begin
        if (bus.memWrite) begin
            for (int b = 0; b < 4; b++)
                if (bus.byteMask[b]) mem[bus.memAddress[7:2]][8*b +: 8] <= bus.memWriteData[8*b +: 8];
        end
        bus.memReadData <= mem[bus.memAddress[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request at a post-edge point; returns one cycle after the response.
    task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wd);
        logic got;
        exp_t e;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        sb.push_back({exp_err, exp_rd});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        got = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            if (c == 1 && !exp_err) begin
                chk({tag, "_addr"}, bus.memAddress, {a[31:2], 2'b00});
                chk({tag, "_we"}, 32'(bus.memWrite), 32'(w));
                chk({tag, "_mask"}, 32'(bus.byteMask), w ? 32'(exp_mask) : 32'd0);
                if (w) chk({tag, "_wdata"}, bus.memWriteData, exp_wd);
            end else begin
                chk({tag, "_we_idle"}, 32'(bus.memWrite), 32'd0);
            end
            if (bus.resp_valid) begin
                got = 1'b1;
                chk({tag, "_latency"}, 32'(c), 32'(exp_lat));
                chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk({tag, "_rdata"}, bus.resp_rdata, e.rd);
                    chk({tag, "_error"}, 32'(bus.resp_error), 32'(e.err));
                end
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_resp expected=resp_valid", tag);
            sb.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",      32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata",      bus.resp_rdata, 32'd0);
        chk("rst_error",      32'(bus.resp_error), 32'd0);
        chk("rst_addr",       bus.memAddress, 32'd0);
        chk("rst_wdata",      bus.memWriteData, 32'd0);
        chk("rst_we",         32'(bus.memWrite), 32'd0);
        chk("rst_mask",       32'(bus.byteMask), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Word store / load
        do_req("sw10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 4'b1111, 32'hDEADBEEF);
        do_req("lw10",  1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 4'b0000, 32'h0);
        // Byte store into lane 3, then signed/unsigned byte loads
        do_req("sb13",  1'b1, 3'b000, 32'h13, 32'h00000080, 32'h0,        1'b0, 2, 4'b1000, 32'h80808080);
        do_req("lb13",  1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 3, 4'b0000, 32'h0);
        do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0, 3, 4'b0000, 32'h0);
        do_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 3, 4'b0000, 32'h0);
        do_req("lb11",  1'b0, 3'b000, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, 3, 4'b0000, 32'h0);
        do_req("lh10",  1'b0, 3'b001, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 4'b0000, 32'h0);
        // Upper halfword store, signed/unsigned halfword loads
        do_req("sh22",  1'b1, 3'b001, 32'h22, 32'h00008001, 32'h0,        1'b0, 2, 4'b1100, 32'h80018001);
        do_req("lh22",  1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 3, 4'b0000, 32'h0);
        do_req("lhu22", 1'b0, 3'b101, 32'h22, 32'h0,        32'h00008001, 1'b0, 3, 4'b0000, 32'h0);
        do_req("lw20",  1'b0, 3'b010, 32'h20, 32'h0,        32'h80010000, 1'b0, 3, 4'b0000, 32'h0);
        // Misaligned and illegal requests
        do_req("lw02",  1'b0, 3'b010, 32'h02, 32'h0,        32'h0,        1'b1, 1, 4'b0000, 32'h0);
        do_req("sh01",  1'b1, 3'b001, 32'h01, 32'hFFFF,     32'h0,        1'b1, 1, 4'b0000, 32'h0);
        do_req("f3011", 1'b0, 3'b011, 32'h00, 32'h0,        32'h0,        1'b1, 1, 4'b0000, 32'h0);
        do_req("sbu",   1'b1, 3'b100, 32'h10, 32'h55,       32'h0,        1'b1, 1, 4'b0000, 32'h0);
        do_req("lw10c", 1'b0, 3'b010, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 3, 4'b0000, 32'h0);

        // Reset during the ACCESS cycle of a store drops the write
        do_req("sw40",  1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0,        1'b0, 2, 4'b1111, 32'hCAFEF00D);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'h12345678;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_we",   32'(bus.memWrite), 32'd0);
        chk("abort_mask", 32'(bus.byteMask), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("abort_no_resp", 32'(bus.resp_valid), 32'd0);
            chk("abort_no_we",   32'(bus.memWrite), 32'd0);
            @(posedge clk); #1;
        end
        do_req("lw40",  1'b0, 3'b010, 32'h40, 32'h0,        32'hCAFEF00D, 1'b0, 3, 4'b0000, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end
endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end between the multicycle CPU core and the BRAM memory port. Accepts one RISC-V load or store per request, encoded by funct3, and drives the word-wide BRAM bus: aligned address, replicated write data and byte mask. It waits out the BRAM's registered read latency, then returns a sign- or zero-extended load result or a store completion. Misaligned and illegal requests are flagged and never reach memory.

## Interface
- READ_LATENCY, 1, cycles from address presentation to valid memReadData (≥1; BRAM is 1)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present; accepted when req_valid && req_ready
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW
- req_addr  input  32  byte address
- req_wdata  input  32  store data (right-justified)
- req_ready  output  1  high only in IDLE with reset low
- resp_valid  output  1  one-cycle completion pulse, no backpressure
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  qualified by resp_valid; misaligned or illegal funct3
- memAddress  output  32  {addr[31:2],2'b00}
- memWriteData  output  32  lane-replicated store data
- memWrite  output  1  write strobe
- byteMask  output  4  byte-lane enables
- memReadData  input  32  BRAM read data

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: on accept, latch write, funct3, addr[1:0], aligned address, lane data and mask.
  - If the request is illegal, go to RESP with error=1.
  - Otherwise go to ACCESS.
- Illegal requests:
  - load funct3 in {011, 110, 111};
  - store funct3[2]==1 or funct3==011;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- ACCESS (1 cycle): drive memAddress and memWriteData. memWrite = req_write && !reset. byteMask = store mask for stores, 0 for loads. Stores go to RESP; loads go to WAIT.
- WAIT: a counter runs READ_LATENCY cycles. memAddress is held; memWrite=0; byteMask=0. On the last WAIT cycle, register the extracted lane from memReadData into resp_rdata, then go to RESP.
- RESP (1 cycle): resp_valid=1, then go to IDLE. resp_rdata and resp_error hold until the next RESP. memAddress and memWriteData hold their last value. memWrite and byteMask are 0 outside ACCESS.
- Store lanes:
  - SB: mask = 4'b0001<<addr[1:0], data = {4{wdata[7:0]}};
  - SH: mask = addr[1] ? 1100 : 0011, data = {2{wdata[15:0]}};
  - SW: mask = 1111, data = wdata.
- Load extraction:
  - byte = memReadData[8*addr[1:0] +: 8];
  - half = memReadData[16*addr[1] +: 16];
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through unchanged.
- No range checking. Out-of-range reads return whatever memReadData carries (possibly Z/X), unmodified.
- Requests presented while req_ready=0 are ignored and not queued.

## Timing
- Reset: when reset is sampled high, the next state is IDLE and the counter is cleared.
- Reset values of all outputs: resp_valid 0, resp_rdata 0, resp_error 0, memAddress 0, memWriteData 0, memWrite 0, byteMask 0. req_ready is 0 while reset is high and 1 in the first cycle after.
- Reset mid-operation: the transaction is dropped and no resp_valid is issued. A store whose ACCESS cycle coincides with reset high is not written, because memWrite is combinationally gated.
- Latency, with request accepted at edge 0 and L = READ_LATENCY:
  - load: ACCESS cycle 1, WAIT cycles 2..L+1, resp_valid in cycle L+2 (cycle 3 for L=1);
  - store: ACCESS cycle 1, resp_valid in cycle 2;
  - error: resp_valid in cycle 1, with no memWrite and no ACCESS.
- Throughput: the next accept is in the cycle after RESP. Back-to-back loads with L=1 complete every 4 cycles; stores every 3.
- memReadData is sampled only at the end of the final WAIT cycle.

## Test plan
- Reset with outputs randomised -> all outputs take reset values; req_ready=1 one cycle after reset drops.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ACCESS shows memAddress=0x10, mask 1111, memWrite=1 for one cycle. Load resp_valid in cycle 3 with rdata 0xDEADBEEF.
- SB addr 0x13 data 0x80 -> mask 1000, memWriteData 0x80808080. LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080.
- SH addr 0x22 data 0x8001 -> mask 1100. LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001.
- LW 0x02, SH 0x01, funct3 011 -> each gives resp_valid in cycle 1 with resp_error=1, and memWrite never asserts.
- Assert reset during the ACCESS cycle of SW 0x40 -> memWrite stays 0, no resp_valid, and a subsequent LW 0x40 returns the old contents.
